// File: rtl/countdown_timer.sv
// countdown_timer
//   Microwave cook-time controller. Holds three BCD digits (m:ss) that feed
//   the seven-segment decoder. Digits are entered from the keypad while idle.
//   While running, the time counts down one second every TICK_DIV clocks.
//   Start, stop, clear and the door switch sequence the timer. A one-cycle
//   done pulse marks the countdown reaching 0:00.
//
//   Ports
//     clk          system clock, rising edge
//     reset        asynchronous active-high reset, clears all state
//     key_valid    one-cycle strobe qualifying key_digit
//     key_digit    keypad BCD digit; values above 9 are ignored
//     start        begin or resume the countdown
//     stop         pause the countdown
//     clear        abort and zero the time
//     door_closed  1 = door shut; counting happens only while shut
//     min          minutes digit (BCD)
//     sec_tens     seconds-tens digit (BCD)
//     sec_ones     seconds-ones digit (BCD)
//     running      1 while counting down
//     paused       1 while paused
//     done         one-cycle pulse when the countdown reaches 0:00
module countdown_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST_COUNT = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [3:0]    min_n, tens_n, ones_n;
  logic          done_n;
  logic [3:0]    dec_min, dec_tens, dec_ones;
  logic          dec_zero, time_zero, hold_req, tick;

  // One-second decrement of the displayed time. A seconds-tens digit of
  // 6..9 (possible from keypad entry) simply counts down; only a tens digit
  // of 0 borrows from the minutes and reloads as 5.
  always_comb begin
    dec_min  = min;
    dec_tens = sec_tens;
    dec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_ones = sec_ones - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_tens = sec_tens - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min - 4'd1;
      end
    end
  end

  assign dec_zero  = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  assign time_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign hold_req  = stop || !door_closed;
  assign tick      = (prescaler == LAST_COUNT);

  // Next-state and datapath decisions. Per-cycle priority is
  // clear > (stop or door open) > start > key, except that the final tick
  // to 0:00 completes even when a stop or door-open arrives with it.
  // A stop on a non-final tick pauses first, so the tick is taken on resume.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    min_n       = min;
    tens_n      = sec_tens;
    ones_n      = sec_ones;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          min_n  = 4'd0;
          tens_n = 4'd0;
          ones_n = 4'd0;
        end else if (hold_req) begin
          state_n = IDLE;
        end else if (start) begin
          if (!time_zero) begin
            state_n     = RUN;
            prescaler_n = '0;
          end
        end else if (key_valid && (key_digit <= 4'd9)) begin
          min_n  = sec_tens;
          tens_n = sec_ones;
          ones_n = key_digit;
        end
      end
      RUN: begin
        if (clear) begin
          state_n     = IDLE;
          prescaler_n = '0;
          min_n       = 4'd0;
          tens_n      = 4'd0;
          ones_n      = 4'd0;
        end else if (tick && dec_zero) begin
          state_n     = IDLE;
          prescaler_n = '0;
          min_n       = 4'd0;
          tens_n      = 4'd0;
          ones_n      = 4'd0;
          done_n      = 1'b1;
        end else if (hold_req) begin
          state_n = PAUSE;
        end else if (tick) begin
          prescaler_n = '0;
          min_n       = dec_min;
          tens_n      = dec_tens;
          ones_n      = dec_ones;
        end else begin
          prescaler_n = prescaler + PW'(1);
        end
      end
      PAUSE: begin
        if (clear) begin
          state_n     = IDLE;
          prescaler_n = '0;
          min_n       = 4'd0;
          tens_n      = 4'd0;
          ones_n      = 4'd0;
        end else if (!hold_req && start) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n     = IDLE;
        prescaler_n = '0;
      end
    endcase
  end

  // State, digits, prescaler and status flags all register together so
  // every output changes on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      min       <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      running   <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      prescaler <= prescaler_n;
      min       <= min_n;
      sec_tens  <= tens_n;
      sec_ones  <= ones_n;
      running   <= (state_n == RUN);
      paused    <= (state_n == PAUSE);
      done      <= done_n;
    end
  end

endmodule
